ifm_frame_filter: RTL and testbench



---
 rtl/ifm_pkg.sv | 17 +
 rtl/ifm_keep_popcnt.sv | 17 +
 rtl/ifm_frame_filter.sv | 139 +++++++++++++
 tb/tb_ifm_frame_filter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifm_pkg.sv
// Shared definitions for the RX ingress frame filter: beat field layout and FSM state encoding.
package ifm_pkg;

    localparam int IFM_BEAT_WIDTH = 73;
    localparam int IFM_TLAST_BIT  = 72;
    localparam int IFM_KEEP_MSB   = 71;
    localparam int IFM_KEEP_LSB   = 64;
    localparam int IFM_DATA_MSB   = 63;
    localparam int IFM_DATA_LSB   = 0;

    typedef enum logic [1:0] {
        IFM_IDLE = 2'd0,
        IFM_PASS = 2'd1,
        IFM_DROP = 2'd2
    } ifm_state_e;

endpackage

// File: rtl/ifm_keep_popcnt.sv
// Combinational population count of a tkeep vector (bytes valid in one beat).
module ifm_keep_popcnt #(
    parameter int KEEP_W = 8,
    parameter int CNT_W  = $clog2(KEEP_W + 1)
) (
    input  logic [KEEP_W-1:0] keep,
    output logic [CNT_W-1:0]  cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            cnt = cnt + CNT_W'(keep[i]);
        end
    end

endmodule

// File: rtl/ifm_frame_filter.sv
// Pops a per-frame good/bad status, then forwards (good) or discards (bad) that frame's beats.
// Statistics counters are built only when IFM_FILTER_STATS_EN is defined.
module ifm_frame_filter
    import ifm_pkg::*;
#(
    parameter int C_DATA_WIDTH = 64,
    parameter int C_KEEP_WIDTH = 8,
    parameter int C_CNT_WIDTH  = 32
) (
    input  logic                                 sys_clk,
    input  logic                                 sys_rst_n,
    input  logic                                 info_fifo_rdata,
    input  logic                                 info_fifo_empty,
    output logic                                 info_fifo_rden,
    input  logic [C_DATA_WIDTH+C_KEEP_WIDTH:0]   data_fifo_rdata,
    input  logic                                 data_fifo_empty,
    output logic                                 data_fifo_rden,
    output logic [C_DATA_WIDTH+C_KEEP_WIDTH:0]   good_fifo_wdata,
    output logic                                 good_fifo_wren,
    input  logic                                 good_fifo_afull,
    output logic [C_CNT_WIDTH-1:0]               stat_good_frames,
    output logic [C_CNT_WIDTH-1:0]               stat_bad_frames,
    output logic [C_CNT_WIDTH-1:0]               stat_good_bytes
);

    localparam int BEAT_W    = C_DATA_WIDTH + C_KEEP_WIDTH + 1;
    localparam int TLAST_BIT = C_DATA_WIDTH + C_KEEP_WIDTH;

    ifm_state_e          state_q, state_d;
    logic                wren_q, wren_d;
    logic [BEAT_W-1:0]   wdata_q, wdata_d;
    logic                beat_last;
    logic                pass_move;
    logic                drop_move;

    assign beat_last = data_fifo_rdata[TLAST_BIT];

    // Pops are combinational so a FWFT head beat can move every cycle.
    always_comb begin
        state_d        = state_q;
        info_fifo_rden = 1'b0;
        data_fifo_rden = 1'b0;
        wren_d         = 1'b0;
        wdata_d        = wdata_q;
        pass_move      = 1'b0;
        drop_move      = 1'b0;
        case (state_q)
            IFM_IDLE: begin
                if (!info_fifo_empty) begin
                    info_fifo_rden = 1'b1;
                    state_d        = info_fifo_rdata ? IFM_PASS : IFM_DROP;
                end
            end
            IFM_PASS: begin
                if (!data_fifo_empty && !good_fifo_afull) begin
                    pass_move      = 1'b1;
                    data_fifo_rden = 1'b1;
                    wren_d         = 1'b1;
                    wdata_d        = data_fifo_rdata;
                    if (beat_last) state_d = IFM_IDLE;
                end
            end
            IFM_DROP: begin
                if (!data_fifo_empty) begin
                    drop_move      = 1'b1;
                    data_fifo_rden = 1'b1;
                    if (beat_last) state_d = IFM_IDLE;
                end
            end
            default: state_d = IFM_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IFM_IDLE;
            wren_q  <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            wren_q  <= wren_d;
            wdata_q <= wdata_d;
        end
    end

    assign good_fifo_wren  = wren_q;
    assign good_fifo_wdata = wdata_q;

`ifdef IFM_FILTER_STATS_EN
    localparam int PC_W = $clog2(C_KEEP_WIDTH + 1);

    logic [PC_W-1:0]        keep_cnt;
    logic [C_CNT_WIDTH-1:0] good_frames_q, good_frames_d;
    logic [C_CNT_WIDTH-1:0] bad_frames_q, bad_frames_d;
    logic [C_CNT_WIDTH-1:0] good_bytes_q, good_bytes_d;

    ifm_keep_popcnt #(
        .KEEP_W (C_KEEP_WIDTH),
        .CNT_W  (PC_W)
    ) u_keep_popcnt (
        .keep   (data_fifo_rdata[C_DATA_WIDTH +: C_KEEP_WIDTH]),
        .cnt    (keep_cnt)
    );

    always_comb begin
        good_frames_d = good_frames_q;
        bad_frames_d  = bad_frames_q;
        good_bytes_d  = good_bytes_q;
        if (pass_move) begin
            good_bytes_d = good_bytes_q + C_CNT_WIDTH'(keep_cnt);
            if (beat_last) good_frames_d = good_frames_q + 1'b1;
        end
        if (drop_move && beat_last) bad_frames_d = bad_frames_q + 1'b1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            good_frames_q <= '0;
            bad_frames_q  <= '0;
            good_bytes_q  <= '0;
        end else begin
            good_frames_q <= good_frames_d;
            bad_frames_q  <= bad_frames_d;
            good_bytes_q  <= good_bytes_d;
        end
    end

    assign stat_good_frames = good_frames_q;
    assign stat_bad_frames  = bad_frames_q;
    assign stat_good_bytes  = good_bytes_q;
`else
    logic unused_moves;
    assign unused_moves     = pass_move ^ drop_move;
    assign stat_good_frames = '0;
    assign stat_bad_frames  = '0;
    assign stat_good_bytes  = '0;
`endif

endmodule

// File: tb/tb_ifm_frame_filter.sv
// Randomized bench for ifm_frame_filter with a queue-based FIFO/scoreboard model.
module tb_ifm_frame_filter;

`ifdef IFM_FILTER_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        info_fifo_rdata, info_fifo_empty, info_fifo_rden;
    logic [72:0] data_fifo_rdata;
    logic        data_fifo_empty, data_fifo_rden;
    logic [72:0] good_fifo_wdata;
    logic        good_fifo_wren, good_fifo_afull;
    logic [31:0] stat_good_frames, stat_bad_frames, stat_good_bytes;

    always #5 sys_clk = ~sys_clk;

    ifm_frame_filter dut (
        .sys_clk          (sys_clk),
        .sys_rst_n        (sys_rst_n),
        .info_fifo_rdata  (info_fifo_rdata),
        .info_fifo_empty  (info_fifo_empty),
        .info_fifo_rden   (info_fifo_rden),
        .data_fifo_rdata  (data_fifo_rdata),
        .data_fifo_empty  (data_fifo_empty),
        .data_fifo_rden   (data_fifo_rden),
        .good_fifo_wdata  (good_fifo_wdata),
        .good_fifo_wren   (good_fifo_wren),
        .good_fifo_afull  (good_fifo_afull),
        .stat_good_frames (stat_good_frames),
        .stat_bad_frames  (stat_bad_frames),
        .stat_good_bytes  (stat_good_bytes)
    );

    typedef struct {
        logic [72:0] beat;
        bit          good;
    } rec_t;

    bit          info_q[$];
    rec_t        data_q[$];
    logic [72:0] exp_wr[$];
    bit          data_hold, afull, rand_mode, in_frame, last_rden;
    int          pend_wr, wr_cnt, pop_cnt, checks, errors;
    logic [31:0] m_gf, m_bf, m_gb;

    function automatic logic [95:0] exp_stats();
        return STATS_EN ? {m_gf, m_bf, m_gb} : 96'd0;
    endfunction

    // One clock: present FIFO heads, observe DUT, retire pops into the model.
    task automatic step();
        rec_t r;
        @(negedge sys_clk);
        if (rand_mode) begin
            afull     = ($urandom_range(0, 3) == 0);
            data_hold = ($urandom_range(0, 4) == 0);
        end
        info_fifo_empty = (info_q.size() == 0);
        info_fifo_rdata = (info_q.size() != 0) ? info_q[0] : 1'b0;
        data_fifo_empty = (data_q.size() == 0) || data_hold;
        data_fifo_rdata = (data_q.size() != 0) ? data_q[0].beat : 73'd0;
        good_fifo_afull = afull;
        #1;
        checks++;
        if (good_fifo_wren !== (pend_wr != 0)) begin
            errors++;
            $display("FAIL wr_latency: wren=%b required=%b", good_fifo_wren, pend_wr != 0);
        end
        if (good_fifo_wren === 1'b1) begin
            wr_cnt++;
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL wr_data: unexpected write %h, none required", good_fifo_wdata);
            end else begin
                if (good_fifo_wdata !== exp_wr[0]) begin
                    errors++;
                    $display("FAIL wr_data: got %h required %h", good_fifo_wdata, exp_wr[0]);
                end
                void'(exp_wr.pop_front());
            end
        end
        pend_wr   = 0;
        last_rden = data_fifo_rden;
        if (info_fifo_rden === 1'b1) begin
            checks++;
            if (in_frame || info_fifo_empty) begin
                errors++;
                $display("FAIL info_pop: pop with in_frame=%b empty=%b, required none", in_frame, info_fifo_empty);
            end else begin
                void'(info_q.pop_front());
                in_frame = 1'b1;
            end
        end
        if (data_fifo_rden === 1'b1) begin
            checks++;
            if (data_fifo_empty || !in_frame) begin
                errors++;
                $display("FAIL data_pop: pop with empty=%b in_frame=%b", data_fifo_empty, in_frame);
            end else begin
                r = data_q.pop_front();
                pop_cnt++;
                if (r.good) begin
                    checks++;
                    if (afull) begin
                        errors++;
                        $display("FAIL afull_pop: good beat popped with afull=1, required stall");
                    end
                    exp_wr.push_back(r.beat);
                    pend_wr = 1;
                    m_gb += 32'($countones(r.beat[71:64]));
                    if (r.beat[72]) m_gf++;
                end else if (r.beat[72]) begin
                    m_bf++;
                end
                if (r.beat[72]) in_frame = 1'b0;
            end
        end
    endtask

    task automatic push_frame(input bit good, input int nb, input bit rnd_keep);
        rec_t r;
        info_q.push_back(good);
        for (int i = 0; i < nb; i++) begin
            r.good        = good;
            r.beat[63:0]  = {$urandom(), $urandom()};
            r.beat[71:64] = rnd_keep ? 8'($urandom_range(1, 255)) : 8'hFF;
            r.beat[72]    = (i == nb - 1);
            data_q.push_back(r);
        end
    endtask

    task automatic drain(input int bound, output bit ok);
        int n = 0;
        while ((info_q.size() != 0 || data_q.size() != 0 || in_frame || pend_wr != 0) && n < bound) begin
            step();
            n++;
        end
        ok = (n < bound);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        info_fifo_empty = 1'b1; info_fifo_rdata = 1'b0;
        data_fifo_empty = 1'b1; data_fifo_rdata = '0; good_fifo_afull = 1'b0;
        #12;
        checks++;
        if ({info_fifo_rden, data_fifo_rden, good_fifo_wren, good_fifo_wdata,
             stat_good_frames, stat_bad_frames, stat_good_bytes} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: wren=%b wdata=%h gf=%0d bf=%0d gb=%0d required all 0",
                     good_fifo_wren, good_fifo_wdata, stat_good_frames, stat_bad_frames, stat_good_bytes);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic test_good_frame();
        rec_t r;
        bit ok;
        int w0 = wr_cnt;
        info_q.push_back(1'b1);
        for (int i = 0; i < 3; i++) begin
            r.good = 1'b1;
            r.beat = {(i == 2), (i == 2) ? 8'h0F : 8'hFF, $urandom(), $urandom()};
            data_q.push_back(r);
        end
        drain(100, ok);
        checks++;
        if (!ok || wr_cnt - w0 != 3) begin
            errors++;
            $display("FAIL good_frame_writes: ok=%b writes=%0d required 3", ok, wr_cnt - w0);
        end
        @(negedge sys_clk);
        checks++;
        if ({stat_good_frames, stat_bad_frames, stat_good_bytes} !==
            (STATS_EN ? {32'd1, 32'd0, 32'd20} : 96'd0)) begin
            errors++;
            $display("FAIL good_frame_stats: gf=%0d bf=%0d gb=%0d required 1/0/20 (stats on)",
                     stat_good_frames, stat_bad_frames, stat_good_bytes);
        end
    endtask

    task automatic test_bad_frame();
        bit ok;
        int w0 = wr_cnt, p0 = pop_cnt;
        push_frame(1'b0, 4, 1'b1);
        push_frame(1'b1, 2, 1'b1);
        drain(100, ok);
        checks++;
        if (!ok || wr_cnt - w0 != 2 || pop_cnt - p0 != 6) begin
            errors++;
            $display("FAIL bad_frame: ok=%b writes=%0d pops=%0d required 2/6", ok, wr_cnt - w0, pop_cnt - p0);
        end
        @(negedge sys_clk);
        checks++;
        if ({stat_good_frames, stat_bad_frames, stat_good_bytes} !== exp_stats()) begin
            errors++;
            $display("FAIL bad_frame_stats: got %h required %h",
                     {stat_good_frames, stat_bad_frames, stat_good_bytes}, exp_stats());
        end
    endtask

    task automatic test_afull();
        bit ok;
        int w0 = wr_cnt, n = 0, p0, stall_pops;
        push_frame(1'b1, 8, 1'b1);
        p0 = pop_cnt;
        while (pop_cnt - p0 < 3 && n < 50) begin step(); n++; end
        afull = 1'b1;
        p0 = pop_cnt;
        for (int i = 0; i < 10; i++) step();
        stall_pops = pop_cnt - p0;
        afull = 1'b0;
        checks++;
        if (stall_pops != 0) begin
            errors++;
            $display("FAIL afull_stall: pops during stall=%0d required 0", stall_pops);
        end
        drain(100, ok);
        checks++;
        if (!ok || wr_cnt - w0 != 8 || exp_wr.size() != 0) begin
            errors++;
            $display("FAIL afull_writes: ok=%b writes=%0d pending=%0d required 8/0", ok, wr_cnt - w0, exp_wr.size());
        end
    endtask

    task automatic test_data_empty();
        bit ok;
        int p0 = pop_cnt;
        data_hold = 1'b1;
        push_frame(1'b1, 2, 1'b1);
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (pop_cnt != p0 || !in_frame) begin
            errors++;
            $display("FAIL hold_empty: pops=%0d in_frame=%b required 0/1", pop_cnt - p0, in_frame);
        end
        data_hold = 1'b0;
        step();
        checks++;
        if (last_rden !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: rden=%b on first non-empty cycle, required 1", last_rden);
        end
        drain(50, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL hold_drain: timeout=1 required 0");
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int w0 = wr_cnt;
        push_frame(1'b1, 1, 1'b1);
        push_frame(1'b0, 1, 1'b1);
        push_frame(1'b1, 1, 1'b1);
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (data_q.size() != 1) begin
            errors++;
            $display("FAIL b2b_bubble: beats left after 5 cycles=%0d required 1", data_q.size());
        end
        step();
        checks++;
        if (data_q.size() != 0 || in_frame) begin
            errors++;
            $display("FAIL b2b_done: beats left after 6 cycles=%0d in_frame=%b required 0/0", data_q.size(), in_frame);
        end
        drain(10, ok);
        @(negedge sys_clk);
        checks++;
        if (!ok || wr_cnt - w0 != 2 || {stat_good_frames, stat_bad_frames, stat_good_bytes} !== exp_stats()) begin
            errors++;
            $display("FAIL b2b_writes: ok=%b writes=%0d stats=%h required 2 / %h",
                     ok, wr_cnt - w0, {stat_good_frames, stat_bad_frames, stat_good_bytes}, exp_stats());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n = 0, p0, w0;
        push_frame(1'b1, 5, 1'b1);
        p0 = pop_cnt;
        while (pop_cnt - p0 < 2 && n < 50) begin step(); n++; end
        sys_rst_n = 1'b0;
        info_q.delete(); data_q.delete(); exp_wr.delete();
        info_fifo_empty = 1'b1; data_fifo_empty = 1'b1;
        pend_wr = 0; in_frame = 1'b0;
        m_gf = 0; m_bf = 0; m_gb = 0;
        #1;
        checks++;
        if ({info_fifo_rden, data_fifo_rden, good_fifo_wren, good_fifo_wdata,
             stat_good_frames, stat_bad_frames, stat_good_bytes} !== '0) begin
            errors++;
            $display("FAIL reset_mid: wren=%b wdata=%h gf=%0d bf=%0d gb=%0d required all 0",
                     good_fifo_wren, good_fifo_wdata, stat_good_frames, stat_bad_frames, stat_good_bytes);
        end
        for (int i = 0; i < 3; i++) step();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        w0 = wr_cnt;
        push_frame(1'b1, 2, 1'b1);
        drain(50, ok);
        @(negedge sys_clk);
        checks++;
        if (!ok || wr_cnt - w0 != 2 || {stat_good_frames, stat_bad_frames, stat_good_bytes} !== exp_stats()) begin
            errors++;
            $display("FAIL reset_recover: ok=%b writes=%0d stats=%h required 2 / %h",
                     ok, wr_cnt - w0, {stat_good_frames, stat_bad_frames, stat_good_bytes}, exp_stats());
        end
    endtask

    task automatic test_random();
        bit ok;
        for (int f = 0; f < 40; f++) push_frame($urandom_range(0, 1) == 1, $urandom_range(1, 6), 1'b1);
        rand_mode = 1'b1;
        drain(5000, ok);
        rand_mode = 1'b0; afull = 1'b0; data_hold = 1'b0;
        step();
        @(negedge sys_clk);
        checks++;
        if (!ok || exp_wr.size() != 0 || {stat_good_frames, stat_bad_frames, stat_good_bytes} !== exp_stats()) begin
            errors++;
            $display("FAIL random: ok=%b pending=%0d stats=%h required 0 / %h",
                     ok, exp_wr.size(), {stat_good_frames, stat_bad_frames, stat_good_bytes}, exp_stats());
        end
    endtask

    initial begin
        checks = 0; errors = 0; pend_wr = 0; wr_cnt = 0; pop_cnt = 0;
        data_hold = 0; afull = 0; rand_mode = 0; in_frame = 0; last_rden = 0;
        m_gf = 0; m_bf = 0; m_gb = 0;
        test_reset();
        test_good_frame();
        test_bad_frame();
        test_afull();
        test_data_empty();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
